// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin single-owner word bus with lock bursts; sources (src_req/src_lock/src_data/src_dst) in, registered src_gnt/bus_data/bus_valid/bus_owner/dst_ld/bus_err out
module bus_arbiter #(
  parameter int word_width = 32,
  parameter int num_src = 4,
  parameter int num_dst = 4,
  parameter int src_idx_w = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [num_src-1:0]            src_req,
  input  logic [num_src-1:0]            src_lock,
  input  logic [num_src*word_width-1:0] src_data,
  input  logic [num_src*num_dst-1:0]    src_dst,
  output logic [num_src-1:0]            src_gnt,
  output logic [word_width-1:0]         bus_data,
  output logic                          bus_valid,
  output logic [src_idx_w-1:0]          bus_owner,
  output logic [num_dst-1:0]            dst_ld,
  output logic                          bus_err
);
  typedef enum logic [1:0] {IDLE, OWN, LOCKED} state_t;
  state_t state, state_nx;
  logic [src_idx_w-1:0] rr_ptr, rr_nx, win, cand;
  logic found, keep, one_hot;
  logic [num_dst-1:0] wdst;
  logic [word_width-1:0] wdata;
  always_comb begin
    keep = state == LOCKED && src_req[bus_owner] && src_lock[bus_owner];
    win = bus_owner;
    found = keep;
    cand = '0;
    for (int j = num_src - 1; j >= 0; j--) begin
      cand = src_idx_w'((int'(rr_ptr) + j) % num_src);
      if (!keep && src_req[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
    wdata = src_data[win * word_width +: word_width];
    wdst = src_dst[win * num_dst +: num_dst];
    one_hot = $onehot(wdst);
    state_nx = !found ? IDLE : src_lock[win] ? LOCKED : OWN;
    rr_nx = found && !keep ? src_idx_w'((int'(win) + 1) % num_src) : rr_ptr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      src_gnt <= '0;
      bus_data <= '0;
      bus_valid <= 1'b0;
      bus_owner <= '0;
      dst_ld <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nx;
      rr_ptr <= rr_nx;
      src_gnt <= found ? num_src'(1) << win : '0;
      bus_data <= found ? wdata : '0;
      bus_valid <= found;
      bus_owner <= found ? win : '0;
      dst_ld <= found && one_hot ? wdst : '0;
      bus_err <= found && !one_hot;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter against a behavioural model
module tb_bus_arbiter;
  localparam int W = 32, N = 4, D = 4, IW = 2;
  logic clk = 0, reset = 1;
  logic [N-1:0] src_req = '1, src_lock = '0;
  logic [N*W-1:0] src_data = '0;
  logic [N*D-1:0] src_dst = '0;
  logic [N-1:0] src_gnt;
  logic [W-1:0] bus_data;
  logic bus_valid;
  logic [IW-1:0] bus_owner;
  logic [D-1:0] dst_ld;
  logic bus_err;
  int total = 0, bad = 0;
  bus_arbiter #(.word_width(W), .num_src(N), .num_dst(D), .src_idx_w(IW)) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_lock(src_lock),
    .src_data(src_data), .src_dst(src_dst), .src_gnt(src_gnt), .bus_data(bus_data),
    .bus_valid(bus_valid), .bus_owner(bus_owner), .dst_ld(dst_ld), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // model: owner held in a lock burst, pointer as a plain integer
  int m_ptr = 0, m_owner = 0, w;
  bit m_lock = 0, m_ready = 0, held;
  logic [N-1:0] e_gnt;
  logic [W-1:0] e_data;
  logic e_valid, e_err;
  int e_owner;
  logic [D-1:0] e_ld, d;
  always @(posedge clk) begin
    if (reset) begin
      m_ptr = 0; m_lock = 0; m_owner = 0;
      e_gnt = 0; e_data = 0; e_valid = 0; e_owner = 0; e_ld = 0; e_err = 0;
    end else begin
      held = m_lock && src_req[m_owner] && src_lock[m_owner];
      w = -1;
      if (held) w = m_owner;
      else for (int j = 0; j < N; j++) if (w < 0 && src_req[(m_ptr + j) % N]) w = (m_ptr + j) % N;
      if (w < 0) begin
        m_lock = 0;
        e_gnt = 0; e_data = 0; e_valid = 0; e_owner = 0; e_ld = 0; e_err = 0;
      end else begin
        d = src_dst[w*D +: D];
        e_gnt = N'(1) << w;
        e_data = src_data[w*W +: W];
        e_valid = 1;
        e_owner = w;
        e_ld = ($countones(d) == 1) ? d : '0;
        e_err = $countones(d) != 1;
        if (!held) m_ptr = (w + 1) % N;
        m_lock = src_lock[w];
        m_owner = w;
      end
    end
    m_ready = 1;
  end
  always @(negedge clk) if (m_ready) begin
    chk("gnt", 64'(src_gnt), 64'(e_gnt));
    chk("data", 64'(bus_data), 64'(e_data));
    chk("valid", 64'(bus_valid), 64'(e_valid));
    chk("ld", 64'(dst_ld), 64'(e_ld));
    chk("err", 64'(bus_err), 64'(e_err));
    if (e_valid) chk("owner", 64'(bus_owner), 64'(e_owner));
  end
  task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lock);
    src_req = req;
    src_lock = lock;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(src_gnt), 0);
    chk("rst_valid", 64'(bus_valid), 0);
    chk("rst_data", 64'(bus_data), 0);
    reset = 0;
    cyc('1, '0);
    chk("first_gnt", 64'(src_gnt), 64'h1);
    cyc('0, '0);
    src_data[2*W +: W] = 32'hDEADBEEF;
    src_dst[2*D +: D] = 4'b0100;
    cyc(4'b0100, '0);
    chk("single_gnt", 64'(src_gnt), 64'h4);
    chk("single_data", 64'(bus_data), 64'hDEADBEEF);
    chk("single_ld", 64'(dst_ld), 64'h4);
    chk("single_owner", 64'(bus_owner), 2);
    cyc('0, '0);
    chk("idle_valid", 64'(bus_valid), 0);
    chk("idle_data", 64'(bus_data), 0);
    reset = 1;
    cyc('0, '0);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      cyc('1, '0);
      chk("rr_gnt", 64'(src_gnt), 64'(1 << (i % 4)));
    end
    cyc(4'b0001, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1011, 4'b0010);
      chk("lock_gnt", 64'(src_gnt), 64'h2);
    end
    cyc(4'b1001, '0);
    chk("after_lock3", 64'(src_gnt), 64'h8);
    cyc(4'b1001, '0);
    chk("after_lock0", 64'(src_gnt), 64'h1);
    src_dst = {4'b1000, 4'b1000, 4'b0011, 4'b0000};
    cyc(4'b0001, '0);
    chk("err0_err", 64'(bus_err), 1);
    chk("err0_ld", 64'(dst_ld), 0);
    cyc(4'b0010, '0);
    chk("err1_err", 64'(bus_err), 1);
    chk("err1_gnt", 64'(src_gnt), 64'h2);
    cyc(4'b0100, '0);
    chk("ok_err", 64'(bus_err), 0);
    chk("ok_ld", 64'(dst_ld), 64'h8);
    cyc(4'b0100, 4'b0100);
    cyc(4'b0100, 4'b0100);
    reset = 1;
    cyc(4'b0101, 4'b0100);
    chk("midrst_gnt", 64'(src_gnt), 0);
    chk("midrst_valid", 64'(bus_valid), 0);
    reset = 0;
    cyc(4'b0101, 4'b0100);
    chk("norelock_gnt", 64'(src_gnt), 64'h1);
    for (int c = 0; c < 2000; c++) begin
      for (int s = 0; s < N; s++) begin
        src_data[s*W +: W] = $urandom;
        src_dst[s*D +: D] = ($urandom_range(0, 3) != 0) ? D'(1) << $urandom_range(0, D - 1) : D'($urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      cyc(N'($urandom), N'($urandom & $urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
